// File: rtl/simple_memwb_if.sv
// Bundles the upstream instruction fields, data-memory port and register write-back port
// of the memory/write-back stage.
interface simple_memwb_if;
  // upstream handshake and instruction fields
  logic        valid_in;
  logic        ready_in;
  logic        writereg;
  logic [2:0]  regaddress;
  logic [1:0]  memwrite;
  logic [15:0] address;
  logic [15:0] storedata;
  logic [15:0] aluresult;
  logic        haltin;

  // data-memory request/acknowledge port
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  // register-file write-back and status
  logic        writeflag;
  logic [2:0]  writetarget;
  logic [15:0] aluwriteval;
  logic [15:0] readoutwriteval;
  logic        readoutSelect;
  logic        haltout;
  logic        memerr;

  modport slave (
    input  valid_in, writereg, regaddress, memwrite, address, storedata, aluresult, haltin,
    input  mem_rdata, mem_ack,
    output ready_in, mem_req, mem_we, mem_addr, mem_wdata,
    output writeflag, writetarget, aluwriteval, readoutwriteval, readoutSelect, haltout, memerr
  );

  modport master (
    output valid_in, writereg, regaddress, memwrite, address, storedata, aluresult, haltin,
    output mem_rdata, mem_ack,
    input  ready_in, mem_req, mem_we, mem_addr, mem_wdata,
    input  writeflag, writetarget, aluwriteval, readoutwriteval, readoutSelect, haltout, memerr
  );
endinterface

// File: rtl/simple_memwb.sv
// Memory-access / write-back stage: one instruction per handshake, load/store through a
// request/acknowledge port with optional time-out, registered register-file write strobe.
module simple_memwb #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic           clock,
  input logic           reset,
  simple_memwb_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e          state_q;
  logic [CntW-1:0] wait_q;
  logic [2:0]      target_q;

  logic accept;
  logic mem_op;
  logic timed_out;

  assign bus.ready_in = (state_q == StIdle) && !bus.haltout;
  assign accept       = bus.valid_in && bus.ready_in;
  assign mem_op       = (bus.memwrite == 2'b01) || (bus.memwrite == 2'b10);
  // Counter value CntLast means this is the TIMEOUT-th cycle of waiting.
  assign timed_out    = (TIMEOUT != 0) && (wait_q == CntLast);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q             <= StIdle;
      wait_q              <= '0;
      target_q            <= '0;
      bus.mem_req         <= 1'b0;
      bus.mem_we          <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_wdata       <= '0;
      bus.writeflag       <= 1'b0;
      bus.writetarget     <= '0;
      bus.aluwriteval     <= '0;
      bus.readoutwriteval <= '0;
      bus.readoutSelect   <= 1'b0;
      bus.haltout         <= 1'b0;
      bus.memerr          <= 1'b0;
    end else begin
      bus.writeflag <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (bus.haltin) begin
              bus.haltout <= 1'b1;
            end else if (mem_op) begin
              state_q       <= StReq;
              wait_q        <= '0;
              target_q      <= bus.regaddress;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= (bus.memwrite == 2'b10);
              bus.mem_addr  <= bus.address;
              bus.mem_wdata <= bus.storedata;
            end else begin
              bus.writeflag     <= bus.writereg;
              bus.writetarget   <= bus.regaddress;
              bus.aluwriteval   <= bus.aluresult;
              bus.readoutSelect <= 1'b0;
            end
          end
        end
        StReq: begin
          // An ack in the final allowed cycle takes priority over the time-out.
          if (bus.mem_ack) begin
            state_q     <= StIdle;
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) begin
              bus.writeflag       <= 1'b1;
              bus.writetarget     <= target_q;
              bus.readoutwriteval <= bus.mem_rdata;
              bus.readoutSelect   <= 1'b1;
            end
          end else if (timed_out) begin
            state_q     <= StIdle;
            bus.mem_req <= 1'b0;
            bus.memerr  <= 1'b1;
          end else begin
            wait_q <= wait_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
